// File: rtl/vmask_packer_pkg.sv
// vmask_packer_pkg: shared vector types, constants and helpers for the mask packer.
package vmask_packer_pkg;
  typedef enum logic [2:0] {SEW8 = 3'd0, SEW16 = 3'd1, SEW32 = 3'd2} sew_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_FULL} state_e;
  localparam logic MASK_AGN = 1'b1;
  // Reserved encodings above SEW32 carry no elements.
  function automatic int elems_per_beat(logic [2:0] sew, int width);
    return (sew > SEW32) ? 0 : width >> (3 + int'(sew));
  endfunction
endpackage

// File: rtl/vmask_packer.sv
// vmask_packer: packs per-element compare bits into agnostic-filled mask words
// and emits them through a one-entry valid/ready output register.
module vmask_packer
  import vmask_packer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = 64,
  parameter int IDX_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    kill_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_WIDTH-1:0]   cmp_i,
  input  logic [DATA_WIDTH/8-1:0] act_i,
  input  logic [2:0]              sew_i,
  input  logic                    last_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [MASK_WIDTH-1:0]   mask_o,
  output logic [IDX_W-1:0]        mask_idx_o,
  output logic                    err_o
);
  localparam int EW = DATA_WIDTH / 8;
  localparam int PW = $clog2(MASK_WIDTH + 1);
  logic [MASK_WIDTH-1:0] acc_q, acc_d, acc_nx, mask_q, mask_d, sel;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d, idx_q, idx_d;
  logic                  vld_q, vld_d, err_q, err_d;
  logic [EW-1:0]         lanes, bits;
  logic                  take, done;
  state_e                state;
  int                    n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '1;
      ptr_q  <= '0;
      cnt_q  <= '0;
      mask_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end
  always_comb begin
    n = elems_per_beat(sew_i, DATA_WIDTH);
    state = (vld_q & ~out_ready_i) ? ST_FULL : (ptr_q != '0) ? ST_ACCUM : ST_IDLE;
    in_ready_o = (state != ST_FULL);
    take = in_valid_i & in_ready_o;
    done = take & (last_i | (int'(ptr_q) + n >= MASK_WIDTH));
    lanes = '0;
    bits = '0;
    for (int k = 0; k < EW; k++) begin
      lanes[k] = (k < n);
      bits[k] = act_i[k] ? cmp_i[k] : MASK_AGN;
    end
    // Untouched accumulator bits are already 1, so the tail fill comes for free.
    sel = MASK_WIDTH'(lanes) << ptr_q;
    acc_nx = (acc_q & ~sel) | ((MASK_WIDTH'(bits) << ptr_q) & sel);
    acc_d = acc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    mask_d = mask_q;
    idx_d = idx_q;
    vld_d = vld_q & ~out_ready_i;
    err_d = take & (sew_i > SEW32);
    if (take) begin
      acc_d = done ? '1 : acc_nx;
      ptr_d = done ? '0 : ptr_q + PW'(n);
    end
    if (done) begin
      mask_d = acc_nx;
      idx_d = cnt_q;
      cnt_d = last_i ? '0 : cnt_q + IDX_W'(1);
      vld_d = 1'b1;
    end
    if (kill_i) begin
      acc_d = '1;
      ptr_d = '0;
      cnt_d = '0;
      mask_d = '0;
      idx_d = '0;
      vld_d = 1'b0;
      err_d = 1'b0;
    end
  end
  assign out_valid_o = vld_q;
  assign mask_o = mask_q;
  assign mask_idx_o = idx_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_vmask_packer.sv
// tb_vmask_packer: directed stimulus against a bit-list/word-queue model of the packer.
module tb_vmask_packer;
  logic        clk = 1'b0, rst = 1'b1, kill_i = 1'b0, in_valid_i = 1'b0, in_ready_o;
  logic [63:0] cmp_i = '0;
  logic [7:0]  act_i = '0;
  logic [2:0]  sew_i = '0;
  logic        last_i = 1'b0, out_valid_o, out_ready_i = 1'b1, err_o;
  logic [63:0] mask_o, hold;
  logic [5:0]  mask_idx_o;
  int total = 0, bad = 0;

  vmask_packer dut (
    .clk(clk), .rst(rst), .kill_i(kill_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .cmp_i(cmp_i), .act_i(act_i), .sew_i(sew_i), .last_i(last_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .mask_o(mask_o), .mask_idx_o(mask_idx_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  typedef struct packed {logic [63:0] m; logic [5:0] i;} exp_t;
  exp_t        q[$];
  logic [63:0] mw = '1;
  int          nb = 0, mc = 0;
  logic        me = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    int  n;
    logic mv, acc;
    if (rst || kill_i) begin
      q.delete();
      mw = '1;
      nb = 0;
      mc = 0;
      me = 1'b0;
    end else begin
      mv = (q.size() != 0);
      acc = in_valid_i && (!mv || out_ready_i);
      me = acc && (sew_i >= 3);
      if (mv && out_ready_i) void'(q.pop_front());
      if (acc) begin
        n = (sew_i < 3) ? (64 >> (3 + sew_i)) : 0;
        for (int k = 0; k < n; k++) mw[nb + k] = act_i[k] ? cmp_i[k] : 1'b1;
        nb += n;
        if (nb == 64 || last_i) begin
          q.push_back(exp_t'{mw, 6'(mc)});
          mc = last_i ? 0 : (mc + 1) % 64;
          mw = '1;
          nb = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(out_valid_o), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready_o), 64'(q.size() == 0 || out_ready_i));
      chk("err", 64'(err_o), 64'(me));
      if (q.size() != 0) begin
        chk("mask", mask_o, q[0].m);
        chk("idx", 64'(mask_idx_o), 64'(q[0].i));
      end
    end
  end

  task automatic beat(input logic [63:0] c, input logic [7:0] a, input logic [2:0] s, input logic l);
    logic r;
    int   n;
    cmp_i = c; act_i = a; sew_i = s; last_i = l; in_valid_i = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      @(negedge clk);
      r = in_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!r) chk("beat_timeout", 64'd0, 64'd1);
    in_valid_i = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    idle(2);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_mask", mask_o, 64'd0);
    chk("rst_idx", 64'(mask_idx_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    rst = 1'b0;
    idle(1);
    // eight 8-bit beats make one full word
    for (int i = 0; i < 8; i++) begin
      beat(64'hA5, 8'hFF, 3'd0, i == 7);
      if (i == 6) chk("t1_no_early", 64'(out_valid_o), 64'd0);
    end
    chk("t1_valid", 64'(out_valid_o), 64'd1);
    chk("t1_mask", mask_o, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("t1_idx", 64'(mask_idx_o), 64'd0);
    idle(2);
    // two words of zeros, idx 0 then 1
    for (int i = 0; i < 32; i++) begin
      beat(64'h0, 8'hFF, 3'd1, i == 31);
      if (i == 15) chk("t3_idx0", 64'(mask_idx_o), 64'd0);
    end
    chk("t3_idx1", 64'(mask_idx_o), 64'd1);
    chk("t3_mask", mask_o, 64'd0);
    idle(2);
    beat(64'b10, 8'b01, 3'd2, 1'b1);
    chk("t2_mask", mask_o, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t2_idx", 64'(mask_idx_o), 64'd0);
    idle(2);
    // backpressure then back-to-back
    out_ready_i = 1'b0;
    beat(64'h1, 8'hFF, 3'd2, 1'b1);
    hold = mask_o;
    chk("t4_hold_val", hold, 64'hFFFF_FFFF_FFFF_FFFD);
    cmp_i = 64'h0; act_i = 8'hFF; sew_i = 3'd2; last_i = 1'b1; in_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_in_ready", 64'(in_ready_o), 64'd0);
      chk("t4_stable", mask_o, hold);
    end
    @(posedge clk);
    #1 out_ready_i = 1'b1;
    @(posedge clk);
    #1 in_valid_i = 1'b0; last_i = 1'b0;
    chk("t4_b2b_valid", 64'(out_valid_o), 64'd1);
    chk("t4_b2b_mask", mask_o, 64'hFFFF_FFFF_FFFF_FFFC);
    idle(2);
    // kill drops a pending word even with a simultaneous handshake
    out_ready_i = 1'b0;
    beat(64'h0, 8'hFF, 3'd2, 1'b1);
    out_ready_i = 1'b1;
    kill_i = 1'b1;
    idle(1);
    kill_i = 1'b0;
    chk("t5_dropped", 64'(out_valid_o), 64'd0);
    // kill mid-word at ptr=24 after one word was emitted
    for (int i = 0; i < 11; i++) beat(64'h3C, 8'hFF, 3'd0, 1'b0);
    kill_i = 1'b1;
    idle(1);
    kill_i = 1'b0;
    beat(64'h1, 8'hFF, 3'd2, 1'b1);
    chk("t5_mask", mask_o, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("t5_idx", 64'(mask_idx_o), 64'd0);
    idle(2);
    // reserved sew flushes with error pulse
    beat(64'h0, 8'hFF, 3'd0, 1'b0);
    beat(64'h0, 8'hFF, 3'd0, 1'b0);
    beat(64'hFFFF, 8'h00, 3'd3, 1'b1);
    chk("t6_err", 64'(err_o), 64'd1);
    chk("t6_mask", mask_o, 64'hFFFF_FFFF_FFFF_0000);
    idle(1);
    chk("t6_err_end", 64'(err_o), 64'd0);
    idle(2);
    // asynchronous reset between edges
    out_ready_i = 1'b0;
    beat(64'h0, 8'hFF, 3'd2, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t7_valid", 64'(out_valid_o), 64'd0);
    chk("t7_mask", mask_o, 64'd0);
    chk("t7_in_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready_i = 1'b1;
    beat(64'h2, 8'hFF, 3'd2, 1'b1);
    chk("t7_after_mask", mask_o, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t7_after_idx", 64'(mask_idx_o), 64'd0);
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
